// File: rtl/ppi_rw_control.sv
// Read/write control and control-word register for an 8255A-style PPI.
// CPU strobes are synchronised to Clock. Each completed write becomes a
// mode set, a Port C bit set/reset, or a port data write, and is delivered
// downstream as registered one-cycle pulses.
//
// state  | meaning
// IDLE   | waiting for a synchronised read or write strobe
// WRITE  | write strobe active, waiting for it to be released
// COMMIT | one cycle: decode the captured address/data and pulse outputs
// READ   | read strobe active, PortRead follows the synchronised address
module ppi_rw_control #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_CW    = 8'h9B
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       CS_n,
    input  logic       RD_n,
    input  logic       WR_n,
    input  logic [1:0] A,
    input  logic [7:0] DataIn,
    output logic [7:0] ControlWord,
    output logic [7:0] CommandBus,
    output logic       GroupA_Enable,
    output logic       GroupB_Enable,
    output logic [2:0] PortWrite,
    output logic [2:0] PortRead,
    output logic       BusConflict
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_READ   = 2'd3;

    // Synchroniser chains hold the raw (active-low) levels so that reset
    // naturally clears them to the inactive state.
    logic [SYNC_STAGES-1:0]      cs_q;
    logic [SYNC_STAGES-1:0]      rd_q;
    logic [SYNC_STAGES-1:0]      wr_q;
    logic [SYNC_STAGES-1:0][1:0] a_q;

    logic       cs_s;
    logic       rd_s;
    logic       wr_s;
    logic [1:0] a_s;
    logic       wr_act;
    logic       rd_act;

    logic [1:0] state;
    logic [1:0] addr_h;
    logic [7:0] data_h;

    assign cs_s   = ~cs_q[SYNC_STAGES-1];
    assign rd_s   = ~rd_q[SYNC_STAGES-1];
    assign wr_s   = ~wr_q[SYNC_STAGES-1];
    assign a_s    = a_q[SYNC_STAGES-1];
    assign wr_act = cs_s & wr_s;
    assign rd_act = cs_s & rd_s;

    function automatic logic [2:0] port_sel(input logic [1:0] addr);
        case (addr)
            2'b00:   port_sel = 3'b001;
            2'b01:   port_sel = 3'b010;
            2'b10:   port_sel = 3'b100;
            default: port_sel = 3'b000;
        endcase
    endfunction

    // Multi-flop synchronisers for the strobes and the port address.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cs_q <= '1;
            rd_q <= '1;
            wr_q <= '1;
            a_q  <= '0;
        end else begin
            cs_q <= {cs_q[SYNC_STAGES-2:0], CS_n};
            rd_q <= {rd_q[SYNC_STAGES-2:0], RD_n};
            wr_q <= {wr_q[SYNC_STAGES-2:0], WR_n};
            a_q  <= {a_q[SYNC_STAGES-2:0], A};
        end
    end

    // Capture address and data straight off the bus while a write is driven;
    // the last sample before the strobe releases is what gets committed.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            addr_h <= 2'b00;
            data_h <= 8'h00;
        end else if (!CS_n && !WR_n) begin
            addr_h <= A;
            data_h <= DataIn;
        end
    end

    // Sequencing FSM with registered command, pulse and select outputs.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state         <= ST_IDLE;
            ControlWord   <= RESET_CW;
            CommandBus    <= RESET_CW;
            GroupA_Enable <= 1'b0;
            GroupB_Enable <= 1'b0;
            PortWrite     <= 3'b000;
            PortRead      <= 3'b000;
            BusConflict   <= 1'b0;
        end else begin
            GroupA_Enable <= 1'b0;
            GroupB_Enable <= 1'b0;
            PortWrite     <= 3'b000;
            case (state)
                ST_IDLE: begin
                    if (wr_act && rd_act) begin
                        BusConflict <= 1'b1;
                    end else if (wr_act) begin
                        state <= ST_WRITE;
                    end else if (rd_act) begin
                        state    <= ST_READ;
                        PortRead <= port_sel(a_s);
                    end
                end
                ST_WRITE: begin
                    if (rd_act) BusConflict <= 1'b1;
                    if (!wr_act) state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    if (addr_h == 2'b11) begin
                        CommandBus <= data_h;
                        if (data_h[7]) begin
                            ControlWord   <= data_h;
                            GroupA_Enable <= 1'b1;
                            GroupB_Enable <= 1'b1;
                        end else if (data_h[3]) begin
                            // Port C bits 4..7 belong to group A
                            GroupA_Enable <= 1'b1;
                        end else begin
                            GroupB_Enable <= 1'b1;
                        end
                    end else begin
                        PortWrite <= port_sel(addr_h);
                    end
                end
                ST_READ: begin
                    if (wr_act) BusConflict <= 1'b1;
                    if (rd_act) begin
                        PortRead <= port_sel(a_s);
                    end else begin
                        PortRead <= 3'b000;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
